// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter that owns the select of a shared 4:1 lane mux and
// presents the granted lane on one valid/ready port, with a per-grant beat cap.
module rr_mux4_arbiter #(
    parameter int W        = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     Req,
    input  logic [4*W-1:0] Din,
    input  logic [3:0]     Last,
    input  logic           OutReady,
    output logic [3:0]     Gnt,
    output logic [1:0]     Sel,
    output logic [W-1:0]   Y,
    output logic           OutValid,
    output logic           Busy
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;
    localparam logic [3:0] HOLD = 4'(MAX_HOLD);

    logic       state;
    logic [1:0] ptr;
    logic [3:0] beat_cnt;
    logic [1:0] winner;
    logic [1:0] idx;
    logic       found;
    logic       beat;
    logic       rel;

    assign Busy     = (state == ST_GRANT);
    assign OutValid = (state == ST_GRANT) && Req[Sel];
    assign Y        = OutValid ? Din[W*Sel +: W] : '0;
    assign beat     = OutValid && OutReady;

    // Release on end-of-burst, beat cap, or the owner dropping its request.
    assign rel = (beat && (Last[Sel] || (beat_cnt + 4'd1 == HOLD))) || !Req[Sel];

    // First requester at or after the rotation pointer wins.
    always_comb begin
        winner = ptr;
        idx    = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && Req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            Gnt      <= '0;
            Sel      <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|Req) begin
                        state    <= ST_GRANT;
                        Gnt      <= 4'b0001 << winner;
                        Sel      <= winner;
                        beat_cnt <= '0;
                    end
                end
                default: begin
                    if (rel) begin
                        state <= ST_IDLE;
                        Gnt   <= '0;
                        ptr   <= Sel + 2'd1;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed bench for rr_mux4_arbiter: each task drives one scenario and
// checks {Gnt, Sel, OutValid, Busy, Y} against hand-computed values.
module tb_rr_mux4_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  Req;
    logic [31:0] Din;
    logic [3:0]  Last;
    logic        OutReady;
    logic [3:0]  Gnt;
    logic [1:0]  Sel;
    logic [7:0]  Y;
    logic        OutValid;
    logic        Busy;

    int vecs;
    int errs;

    rr_mux4_arbiter #(.W(8), .MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n), .Req(Req), .Din(Din), .Last(Last),
        .OutReady(OutReady), .Gnt(Gnt), .Sel(Sel), .Y(Y),
        .OutValid(OutValid), .Busy(Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; Req = '0; Last = '0; OutReady = 1'b1; Din = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] exp;
        rst_n = 1'b0; Req = 4'b1111; Last = '0; OutReady = 1'b1; Din = 32'h13121110;
        tick();
        tick();
        #1;
        exp = {4'b0000, 2'd0, 1'b0, 1'b0, 8'h00};
        vecs++;
        if ({Gnt, Sel, OutValid, Busy, Y} !== exp) begin
            $display("FAIL reset_outputs got=%h exp=%h", {Gnt, Sel, OutValid, Busy, Y}, exp);
            errs++;
        end
        vecs++;
        if (dut.ptr !== 2'd0 || dut.beat_cnt !== 4'd0) begin
            $display("FAIL reset_regs got ptr=%0d cnt=%0d exp ptr=0 cnt=0", dut.ptr, dut.beat_cnt);
            errs++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [15:0] exp;
        apply_reset();
        Req = 4'b0001; Din = 32'h000000A5; Last = '0; OutReady = 1'b1;
        #1;
        exp = 16'h0000;
        vecs++;
        if ({Gnt, Sel, OutValid, Busy, Y} !== exp) begin
            $display("FAIL single_idle got=%h exp=%h", {Gnt, Sel, OutValid, Busy, Y}, exp);
            errs++;
        end
        for (int b = 0; b < 4; b++) begin
            tick();
            #1;
            exp = {4'b0001, 2'd0, 1'b1, 1'b1, 8'hA5};
            vecs++;
            if ({Gnt, Sel, OutValid, Busy, Y} !== exp) begin
                $display("FAIL single_beat%0d got=%h exp=%h", b, {Gnt, Sel, OutValid, Busy, Y}, exp);
                errs++;
            end
        end
        tick();
        #1;
        exp = 16'h0000;
        vecs++;
        if ({Gnt, Sel, OutValid, Busy, Y} !== exp || dut.ptr !== 2'd1) begin
            $display("FAIL single_bubble got=%h ptr=%0d exp=%h ptr=1", {Gnt, Sel, OutValid, Busy, Y}, dut.ptr, exp);
            errs++;
        end
        tick();
        #1;
        exp = {4'b0001, 2'd0, 1'b1, 1'b1, 8'hA5};
        vecs++;
        if ({Gnt, Sel, OutValid, Busy, Y} !== exp) begin
            $display("FAIL single_regrant got=%h exp=%h", {Gnt, Sel, OutValid, Busy, Y}, exp);
            errs++;
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] exp;
        logic [3:0]  oh;
        int          lane;
        apply_reset();
        Req = 4'b1111; Last = 4'b1111; OutReady = 1'b1; Din = 32'h13121110;
        for (int g = 0; g < 5; g++) begin
            tick();
            #1;
            lane = g % 4;
            oh = 4'b0001 << lane;
            exp = {oh, 2'(lane), 1'b1, 1'b1, 8'(8'h10 + lane)};
            vecs++;
            if ({Gnt, Sel, OutValid, Busy, Y} !== exp) begin
                $display("FAIL rr_grant%0d got=%h exp=%h", g, {Gnt, Sel, OutValid, Busy, Y}, exp);
                errs++;
            end
            tick();
            #1;
            exp = {4'b0000, 2'(lane), 1'b0, 1'b0, 8'h00};
            vecs++;
            if ({Gnt, Sel, OutValid, Busy, Y} !== exp) begin
                $display("FAIL rr_bubble%0d got=%h exp=%h", g, {Gnt, Sel, OutValid, Busy, Y}, exp);
                errs++;
            end
        end
    endtask

    task automatic test_forced_last();
        logic [15:0] exp;
        apply_reset();
        Req = 4'b0011; Last = 4'b0000; OutReady = 1'b1; Din = 32'h0000B1A0;
        for (int b = 0; b < 4; b++) begin
            tick();
            #1;
            exp = {4'b0001, 2'd0, 1'b1, 1'b1, 8'hA0};
            vecs++;
            if ({Gnt, Sel, OutValid, Busy, Y} !== exp) begin
                $display("FAIL fl_lane0_beat%0d got=%h exp=%h", b, {Gnt, Sel, OutValid, Busy, Y}, exp);
                errs++;
            end
        end
        tick();
        #1;
        vecs++;
        if (Busy !== 1'b0 || dut.ptr !== 2'd1) begin
            $display("FAIL fl_rel1 got busy=%b ptr=%0d exp busy=0 ptr=1", Busy, dut.ptr);
            errs++;
        end
        for (int b = 0; b < 2; b++) begin
            tick();
            Last = (b == 1) ? 4'b0010 : 4'b0000;
            #1;
            exp = {4'b0010, 2'd1, 1'b1, 1'b1, 8'hB1};
            vecs++;
            if ({Gnt, Sel, OutValid, Busy, Y} !== exp) begin
                $display("FAIL fl_lane1_beat%0d got=%h exp=%h", b, {Gnt, Sel, OutValid, Busy, Y}, exp);
                errs++;
            end
        end
        tick();
        Last = 4'b0000;
        #1;
        exp = {4'b0000, 2'd1, 1'b0, 1'b0, 8'h00};
        vecs++;
        if ({Gnt, Sel, OutValid, Busy, Y} !== exp || dut.ptr !== 2'd2) begin
            $display("FAIL fl_rel2 got=%h ptr=%0d exp=%h ptr=2", {Gnt, Sel, OutValid, Busy, Y}, dut.ptr, exp);
            errs++;
        end
        tick();
        #1;
        exp = {4'b0001, 2'd0, 1'b1, 1'b1, 8'hA0};
        vecs++;
        if ({Gnt, Sel, OutValid, Busy, Y} !== exp) begin
            $display("FAIL fl_lane0_again got=%h exp=%h", {Gnt, Sel, OutValid, Busy, Y}, exp);
            errs++;
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp;
        apply_reset();
        Req = 4'b0100; Last = '0; OutReady = 1'b0; Din = 32'h00C20000;
        exp = {4'b0100, 2'd2, 1'b1, 1'b1, 8'hC2};
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            vecs++;
            if ({Gnt, Sel, OutValid, Busy, Y} !== exp || dut.beat_cnt !== 4'd0) begin
                $display("FAIL bp_stall%0d got=%h cnt=%0d exp=%h cnt=0", c, {Gnt, Sel, OutValid, Busy, Y}, dut.beat_cnt, exp);
                errs++;
            end
        end
        tick();
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
        #1;
        vecs++;
        if ({Gnt, Sel, OutValid, Busy, Y} !== exp || dut.beat_cnt !== 4'd1) begin
            $display("FAIL bp_one_beat got=%h cnt=%0d exp=%h cnt=1", {Gnt, Sel, OutValid, Busy, Y}, dut.beat_cnt, exp);
            errs++;
        end
    endtask

    task automatic test_req_drop();
        logic [15:0] exp;
        apply_reset();
        Req = 4'b1000; Last = '0; OutReady = 1'b0; Din = 32'hD300E100;
        tick();
        Req = 4'b0010;
        #1;
        exp = {4'b1000, 2'd3, 1'b0, 1'b1, 8'h00};
        vecs++;
        if ({Gnt, Sel, OutValid, Busy, Y} !== exp) begin
            $display("FAIL drop_nobeat got=%h exp=%h", {Gnt, Sel, OutValid, Busy, Y}, exp);
            errs++;
        end
        tick();
        #1;
        exp = {4'b0000, 2'd3, 1'b0, 1'b0, 8'h00};
        vecs++;
        if ({Gnt, Sel, OutValid, Busy, Y} !== exp || dut.ptr !== 2'd0) begin
            $display("FAIL drop_release got=%h ptr=%0d exp=%h ptr=0", {Gnt, Sel, OutValid, Busy, Y}, dut.ptr, exp);
            errs++;
        end
        tick();
        #1;
        exp = {4'b0010, 2'd1, 1'b1, 1'b1, 8'hE1};
        vecs++;
        if ({Gnt, Sel, OutValid, Busy, Y} !== exp) begin
            $display("FAIL drop_next_lane1 got=%h exp=%h", {Gnt, Sel, OutValid, Busy, Y}, exp);
            errs++;
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp;
        apply_reset();
        Req = 4'b0010; Last = '0; OutReady = 1'b1; Din = 32'h0000E1A7;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        exp = {4'b0010, 2'd1, 1'b1, 1'b1, 8'hE1};
        vecs++;
        if ({Gnt, Sel, OutValid, Busy, Y} !== exp || dut.beat_cnt !== 4'd2) begin
            $display("FAIL rm_before got=%h cnt=%0d exp=%h cnt=2", {Gnt, Sel, OutValid, Busy, Y}, dut.beat_cnt, exp);
            errs++;
        end
        tick();
        rst_n = 1'b1; Req = 4'b1111;
        #1;
        exp = 16'h0000;
        vecs++;
        if ({Gnt, Sel, OutValid, Busy, Y} !== exp || dut.beat_cnt !== 4'd0 || dut.ptr !== 2'd0) begin
            $display("FAIL rm_after got=%h cnt=%0d ptr=%0d exp=%h cnt=0 ptr=0", {Gnt, Sel, OutValid, Busy, Y}, dut.beat_cnt, dut.ptr, exp);
            errs++;
        end
        tick();
        #1;
        exp = {4'b0001, 2'd0, 1'b1, 1'b1, 8'hA7};
        vecs++;
        if ({Gnt, Sel, OutValid, Busy, Y} !== exp) begin
            $display("FAIL rm_regrant0 got=%h exp=%h", {Gnt, Sel, OutValid, Busy, Y}, exp);
            errs++;
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rst_n = 1'b0; Req = '0; Din = '0; Last = '0; OutReady = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_forced_last();
        test_backpressure();
        test_req_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
